// File: rtl/burst_decoder_pkg.sv
// Shared types and defaults for the burst_decoder slice.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned LEN_DEFAULT = 2;

  // Burst count is one bit wider than the address so a full sweep fits.
  function automatic int unsigned cw_default(input int unsigned len);
    return len + 1;
  endfunction

endpackage

// File: rtl/burst_decoder_if.sv
// Start/step handshake and select outputs of burst_decoder.
// DECODER_BROADCAST_EN adds the Bcast request line.
interface burst_decoder_if
  import decoder_pkg::*;
#(
  parameter int unsigned LEN = LEN_DEFAULT,
  parameter int unsigned CW  = cw_default(LEN)
) ();

  logic              Start;
  logic [LEN-1:0]    Dir;
  logic [CW-1:0]     Count;
  logic              Step;
  logic              Ready;
  logic              Busy;
  logic              Done;
  logic [2**LEN-1:0] Sal;
  logic [LEN-1:0]    Idx;
`ifdef DECODER_BROADCAST_EN
  logic              Bcast;

  modport master (output Start, Dir, Count, Step, Bcast,
                  input  Ready, Busy, Done, Sal, Idx);
  modport slave  (input  Start, Dir, Count, Step, Bcast,
                  output Ready, Busy, Done, Sal, Idx);
`else
  modport master (output Start, Dir, Count, Step,
                  input  Ready, Busy, Done, Sal, Idx);
  modport slave  (input  Start, Dir, Count, Step,
                  output Ready, Busy, Done, Sal, Idx);
`endif

endinterface

// File: rtl/burst_decoder_unit.sv
// Combinational LEN-to-2**LEN one-hot decoder.
module DecoderUnit #(
  parameter int unsigned LEN = 2
) (
  input  logic [LEN-1:0]    addr,
  output logic [2**LEN-1:0] sel
);

  always_comb begin
    sel       = '0;
    sel[addr] = 1'b1;
  end

endmodule

// File: rtl/burst_decoder.sv
// Burst one-hot select generator: walks Idx from Dir for Count steps.
// DECODER_BROADCAST_EN adds an all-ones single-step broadcast burst.
module burst_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned LEN = LEN_DEFAULT,
  parameter int unsigned CW  = cw_default(LEN)
) (
  input logic            clk,
  input logic            rst,
  burst_decoder_if.slave bus
);

  localparam int unsigned NSEL = 2**LEN;

  state_t          state, state_n;
  logic [CW-1:0]   rem, rem_n;
  logic [LEN-1:0]  idx_n;
  logic [NSEL-1:0] pattern;
  logic [NSEL-1:0] sal_n;
`ifdef DECODER_BROADCAST_EN
  logic            bcast, bcast_n;
`endif

  // Decode the next address so Sal is registered in step with Idx.
  DecoderUnit #(.LEN(LEN)) u_dec (
    .addr (idx_n),
    .sel  (pattern)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rem     <= '0;
      bus.Idx <= '0;
      bus.Sal <= '0;
`ifdef DECODER_BROADCAST_EN
      bcast   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      bus.Idx <= idx_n;
      bus.Sal <= sal_n;
`ifdef DECODER_BROADCAST_EN
      bcast   <= bcast_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    idx_n   = bus.Idx;
`ifdef DECODER_BROADCAST_EN
    bcast_n = bcast;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
`ifdef DECODER_BROADCAST_EN
          if (bus.Bcast) begin
            state_n = ST_RUN;
            idx_n   = '0;
            rem_n   = CW'(1);
            bcast_n = 1'b1;
          end else
`endif
          if (bus.Count == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
            idx_n   = bus.Dir;
            rem_n   = bus.Count;
`ifdef DECODER_BROADCAST_EN
            bcast_n = 1'b0;
`endif
          end
        end
      end
      ST_RUN: begin
        if (bus.Step) begin
          if (rem > CW'(1)) begin
            idx_n = bus.Idx + LEN'(1);
            rem_n = rem - CW'(1);
          end else begin
            state_n = ST_DONE;
            rem_n   = '0;
`ifdef DECODER_BROADCAST_EN
            bcast_n = 1'b0;
`endif
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    sal_n = (state_n == ST_RUN) ? pattern : '0;
`ifdef DECODER_BROADCAST_EN
    if (state_n == ST_RUN && bcast_n) sal_n = '1;
`endif
  end

  assign bus.Ready = (state == ST_IDLE);
  assign bus.Busy  = (state == ST_RUN);
  assign bus.Done  = (state == ST_DONE);

endmodule

// File: doc/burst_decoder.md
# burst_decoder

Sequential, parametrised one-hot select generator for register-file write enables. It accepts a start address and a burst count through a start handshake. It then drives a registered one-hot select that walks consecutive addresses, wrapping modulo 2**LEN, advancing only on Step. It sits between the bus/control FSM and the register bank, and replaces direct combinational decoding wherever burst writes are needed.

## Interface
- LEN, 2, address width; select width is 2**LEN
- CW, LEN+1, burst count width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Start  in  1  burst request; accepted only when Ready=1
- Dir  in  LEN  start address, sampled on accepted Start
- Count  in  CW  number of selects in the burst, sampled on accepted Start
- Step  in  1  advance enable; while low, the current select is held
- Ready  out  1  high in IDLE only (combinational from state)
- Busy  out  1  high in RUN
- Done  out  1  one-cycle pulse at burst end
- Sal  out  2**LEN  registered one-hot select; all-zero when not in RUN
- Idx  out  LEN  registered current address

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- **IDLE**
  - Ready=1, Sal=0.
  - Start with Count>0 moves to RUN: Idx=Dir, remaining=Count, Sal=1<<Dir.
  - Start with Count=0 moves directly to DONE; no select is ever asserted.
- **RUN**
  - Busy=1 and Sal=1<<Idx.
  - With Step=1 and remaining>1: Idx=Idx+1 mod 2**LEN, and remaining decrements.
  - With Step=1 and remaining=1: move to DONE, Sal=0.
  - With Step=0: all registers hold.
- **DONE**
  - Done=1 and Sal=0 for exactly one cycle, then IDLE unconditionally.
  - Start is ignored in DONE.
- Start is ignored outside IDLE. No queueing; the requester retries once Ready=1.
- Wrap-around: Idx of 2**LEN-1 followed by a step gives 0.
- Bursts longer than 2**LEN are allowed and revisit addresses. The maximum Count is 2**CW-1.
- Sal is always one-hot or all-zero, never multi-hot (except broadcast; see Configuration).
- Reset values: state=IDLE, Sal=0, Idx=0, remaining=0, Busy=0, Done=0. Ready=1 after reset.
- Asserting rst mid-burst immediately clears Sal and Busy (asynchronous). No Done pulse is produced for the aborted burst.

## Timing
- Accepted Start at edge N gives Sal valid from edge N+1, i.e. one-cycle latency.
- A burst of Count=K with Step held high:
  - Sal is active for edges N+1..N+K.
  - Done is high in cycle N+K+1.
  - Ready returns in cycle N+K+2.
- Each Step=0 cycle in RUN extends the burst by one cycle.
- Count=0 gives Done in cycle N+1 and Ready in cycle N+2.
- Back-to-back bursts have a minimum gap of 2 cycles between the last select and the next first select.

## Configuration
- The macro DECODER_BROADCAST_EN controls broadcast support.
- **Defined:**
  - Adds input port Bcast (1 bit), sampled with an accepted Start.
  - Start with Bcast=1 enters RUN with Sal all ones and remaining=1, ignoring Dir and Count.
  - The broadcast burst lasts one Step and then goes to DONE as normal.
  - Idx is loaded with 0.
- **Undefined:** the Bcast port is absent and Sal is strictly one-hot or zero.

## Structure
- Package decoder_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the CW default expression.
- Sub-module: instantiate the existing combinational DecoderUnit (parameter LEN) to produce the one-hot pattern from the next-Idx value.
  - The pattern is gated to zero outside next-state RUN and registered into Sal.
  - With DECODER_BROADCAST_EN, the gate is ORed with the all-ones broadcast.

## Test plan
All scenarios use LEN=2.
- **Reset:** rst high mid-burst → Sal=0000, Busy=0, Idx=0 the same cycle; Ready=1 after release; no Done pulse.
- **Basic burst:** Start, Dir=1, Count=3, Step=1 → Sal=0010, 0100, 1000 on consecutive cycles, then Done=1 with Sal=0000, then Ready=1.
- **Wrap and stall:** Dir=3, Count=3, Step pattern 1,0,1,1 → Sal=1000, 0001, 0001, 0010; Done follows the last step.
- **Zero count and ignored Start:** Count=0 → Done the next cycle, Sal never nonzero. Start asserted during RUN or DONE → no effect on Idx or remaining.
- **Long burst:** Dir=0, Count=6 → Sal sequence 0001, 0010, 0100, 1000, 0001, 0010, then Done.
- **Broadcast (with DECODER_BROADCAST_EN):** Start with Bcast=1 → Sal=1111 for one cycle, then Done. Bcast=0 → behaviour identical to the basic burst scenario.
